// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for the register file's single write port, with a pending-write scoreboard.
// Optional build macro WB_R0_DISCARD_EN: writes and reservations targeting R0 are dropped.
module regfile_wb_arbiter #(
    parameter int unsigned STARVE_LIMIT = 3,
    parameter int unsigned CNT_W        = 4
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        a_valid,
    input  logic [3:0]  a_reg,
    input  logic [15:0] a_data,
    output logic        a_ready,

    input  logic        b_valid,
    input  logic [3:0]  b_reg,
    input  logic [15:0] b_data,
    output logic        b_ready,

    input  logic        rsv_valid,
    input  logic [3:0]  rsv_reg,

    output logic        wr_en,
    output logic [3:0]  wr_reg,
    output logic [15:0] wr_data,
    output logic [15:0] busy
);

    localparam logic [CNT_W-1:0] StarveMax = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] starveCnt;
    logic             aWins;
    logic             grantA;
    logic             grantB;
    logic             anyGrant;
    logic [3:0]       grantReg;
    logic [15:0]      grantData;
    logic             grantWrite;
    logic             rsvTakes;
    logic [15:0]      busyNext;

    // B normally wins a tie; A takes the port once it has waited STARVE_LIMIT cycles.
    always_comb begin
        aWins     = a_valid && (!b_valid || (starveCnt == StarveMax));
        grantA    = rst && aWins;
        grantB    = rst && b_valid && !aWins;
        anyGrant  = grantA || grantB;
        grantReg  = grantA ? a_reg  : b_reg;
        grantData = grantA ? a_data : b_data;
`ifdef WB_R0_DISCARD_EN
        grantWrite = anyGrant && (grantReg != 4'd0);
        rsvTakes   = rsv_valid && (rsv_reg != 4'd0);
`else
        grantWrite = anyGrant;
        rsvTakes   = rsv_valid;
`endif
    end

    assign a_ready = grantA;
    assign b_ready = grantB;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starveCnt <= '0;
        end else if (a_valid && !grantA) begin
            if (starveCnt != StarveMax) begin
                starveCnt <= starveCnt + 1'b1;
            end
        end else begin
            starveCnt <= '0;
        end
    end

    // Registered write port: a grant in cycle N appears on the register file in N+1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_en   <= 1'b0;
            wr_reg  <= 4'd0;
            wr_data <= 16'd0;
        end else begin
            wr_en <= grantWrite;
            if (grantWrite) begin
                wr_reg  <= grantReg;
                wr_data <= grantData;
            end
        end
    end

    // Clear is applied before set so a same-register reservation at the retiring edge survives.
    always_comb begin
        // NOTE: busyNext is defaulted first so the partial bit updates below never infer a latch.
        busyNext = busy;
        if (wr_en) begin
            busyNext[wr_reg] = 1'b0;
        end
        if (rsvTakes) begin
            busyNext[rsv_reg] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy <= 16'd0;
        end else begin
            busy <= busyNext;
        end
    end

endmodule
